// File: rtl/ah4_key_conditioner_if.sv
// ah4_key_conditioner_if: KEY pin input and conditioned outputs exchanged
// between the key conditioner and the AH-4 tuner state machine.
interface ah4_key_conditioner_if;
    logic        key_raw;
    logic        millisec_pulse;
    logic        key;
    logic        key_fall;
    logic        key_rise;
    logic [11:0] low_ms;
    logic        low_valid;
    logic        stuck_low;

    modport master (
        input  key_raw,
        output millisec_pulse, key, key_fall, key_rise, low_ms, low_valid, stuck_low
    );

    modport slave (
        output key_raw,
        input  millisec_pulse, key, key_fall, key_rise, low_ms, low_valid, stuck_low
    );
endinterface

// File: rtl/ah4_key_conditioner.sv
// ah4_key_conditioner: 1 ms tick generator plus KEY synchroniser, debouncer,
// low-pulse timer and stuck-low detector for the AH-4 tuner controller.
// The key state (released / debouncing / low) is carried by key_q together
// with db_cnt; there is no separate state machine.
module ah4_key_conditioner #(
    parameter int TICKS_PER_MS = 76800,
    parameter int DEBOUNCE_MS  = 4,
    parameter int STUCK_MS     = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ah4_key_conditioner_if.master bus
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICKS_PER_MS - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_MS - 1);
    localparam logic [11:0]   LOW_MAX     = 12'hFFF;
    localparam logic [11:0]   STUCK_LIMIT = 12'(STUCK_MS);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          tick_q;
    logic          sync_meta;
    logic          ksync;
    logic [DW-1:0] db_cnt;
    logic          key_q;
    logic          fall_q;
    logic          rise_q;
    logic [11:0]   low_cnt;
    logic [11:0]   low_inc;
    logic [11:0]   low_ms_q;
    logic          valid_q;
    logic          stuck_q;
    logic          accept;
    logic          fall_now;
    logic          rise_now;

    // The tick is registered off the next prescaler value so it lines up
    // with the cycle in which the count sits at its last value.
    assign presc_next = (presc == PRESC_LAST) ? '0 : presc + 1'b1;

    // A changed level is accepted on the tick that completes its debounce run.
    assign accept   = tick_q && (ksync != key_q) && (db_cnt == DB_LAST);
    assign fall_now = accept && !ksync;
    assign rise_now = accept && ksync;

    // Saturating next value of the low-duration counter.
    assign low_inc = (low_cnt == LOW_MAX) ? low_cnt : low_cnt + 12'd1;

    // Millisecond prescaler and its registered strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            presc  <= presc_next;
            tick_q <= (presc_next == PRESC_LAST);
        end
    end

    // Two-flop synchroniser for the open-collector KEY line, idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            ksync     <= 1'b1;
        end else begin
            sync_meta <= bus.key_raw;
            ksync     <= sync_meta;
        end
    end

    // Debounce on ms ticks: any agreeing tick restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            key_q  <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            fall_q <= fall_now;
            rise_q <= rise_now;
            if (tick_q) begin
                if (ksync == key_q || accept) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
                if (accept) begin
                    key_q <= ksync;
                end
            end
        end
    end

    // Low-pulse timer: cleared on the fall tick, counts through the rise tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt  <= '0;
            low_ms_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            valid_q <= rise_now;
            if (fall_now) begin
                low_cnt <= '0;
            end else if (tick_q && !key_q) begin
                low_cnt <= low_inc;
            end
            if (rise_now) begin
                low_ms_q <= low_inc;
                stuck_q  <= 1'b0;
            end else if (tick_q && !key_q && low_inc == STUCK_LIMIT) begin
                stuck_q  <= 1'b1;
            end
        end
    end

    assign bus.millisec_pulse = tick_q;
    assign bus.key            = key_q;
    assign bus.key_fall       = fall_q;
    assign bus.key_rise       = rise_q;
    assign bus.low_ms         = low_ms_q;
    assign bus.low_valid      = valid_q;
    assign bus.stuck_low      = stuck_q;

endmodule
